// File: rtl/udp_rx_word_unpack.sv
// udp_rx_word_unpack
// Receive-side UDP payload unpacker. It takes a UDP header and the payload byte
// stream from the UDP stack and filters datagrams on destination port. Accepted
// payload bytes are packed big-endian into 16-bit words. The words are buffered
// in a small first-word-fall-through FIFO and handed to the consumer with
// valid/ready.

module udp_rx_word_unpack #(
  parameter int          DEPTH     = 4,
  parameter logic [15:0] PORT      = 16'd1234,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        udp_rx_hdr_valid,
  output logic        udp_rx_hdr_ready,
  input  logic [15:0] udp_rx_dest_port,
  input  logic        udp_rx_payload_valid,
  output logic        udp_rx_payload_ready,
  input  logic        udp_rx_payload_last,
  input  logic [7:0]  udp_rx_payload_data,
  output logic [15:0] o_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic        o_err_odd,
  output logic        o_drop
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      hi_byte_q, hi_byte_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            err_odd_q, err_odd_d;
  logic            drop_q, drop_d;

  logic            fifo_full_s;
  logic            hdr_fire_s;
  logic            beat_s;
  logic            push_s;
  logic            pop_s;
  logic            port_miss_s;
  logic [15:0]     push_word_s;

  assign fifo_full_s = (count_q == CW'(DEPTH));
  assign o_valid     = (count_q != {CW{1'b0}});
  assign o_data      = mem_q[rd_ptr_q];
  assign o_err_odd   = err_odd_q;
  assign o_drop      = drop_q;

  assign hdr_fire_s  = udp_rx_hdr_valid && udp_rx_hdr_ready;
  assign beat_s      = udp_rx_payload_valid && udp_rx_payload_ready;
  assign push_s      = beat_s && (state_q == S_LOW);
  assign pop_s       = o_valid && i_ready;
  assign port_miss_s = FILTER_EN && (udp_rx_dest_port != PORT);
  assign push_word_s = {hi_byte_q, udp_rx_payload_data};

  // Ready signals depend only on state and FIFO occupancy, never on valid.
  always_comb begin
    udp_rx_hdr_ready     = 1'b0;
    udp_rx_payload_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        udp_rx_hdr_ready     = 1'b1;
        udp_rx_payload_ready = 1'b0;
      end
      S_HIGH: begin
        udp_rx_hdr_ready     = 1'b0;
        udp_rx_payload_ready = 1'b1;
      end
      S_LOW: begin
        udp_rx_hdr_ready     = 1'b0;
        udp_rx_payload_ready = !fifo_full_s;
      end
      S_DROP: begin
        udp_rx_hdr_ready     = 1'b0;
        udp_rx_payload_ready = 1'b1;
      end
      default: begin
        udp_rx_hdr_ready     = 1'b0;
        udp_rx_payload_ready = 1'b0;
      end
    endcase
  end

  // Datagram state machine: next state, held high byte and the status pulses.
  always_comb begin
    state_d   = state_q;
    hi_byte_d = hi_byte_q;
    err_odd_d = 1'b0;
    drop_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hdr_fire_s) begin
          if (port_miss_s) begin
            state_d = S_DROP;
            drop_d  = 1'b1;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HIGH: begin
        if (beat_s) begin
          hi_byte_d = udp_rx_payload_data;
          if (udp_rx_payload_last) begin
            // A lone high byte cannot form a word; it is flagged and discarded.
            state_d   = S_IDLE;
            err_odd_d = 1'b1;
          end else begin
            state_d = S_LOW;
          end
        end else begin
          state_d = S_HIGH;
        end
      end
      S_LOW: begin
        if (beat_s) begin
          if (udp_rx_payload_last) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_HIGH;
          end
        end else begin
          state_d = S_LOW;
        end
      end
      S_DROP: begin
        if (beat_s && udp_rx_payload_last) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DROP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // FIFO pointer and occupancy update; simultaneous push and pop keep count.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      hi_byte_q <= 8'h00;
      wr_ptr_q  <= {AW{1'b0}};
      rd_ptr_q  <= {AW{1'b0}};
      count_q   <= {CW{1'b0}};
      err_odd_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hi_byte_q <= hi_byte_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      err_odd_q <= err_odd_d;
      drop_q    <= drop_d;
    end
  end

  // Word storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (push_s) begin
      mem_q[wr_ptr_q] <= push_word_s;
    end
  end

endmodule

// File: tb/tb_udp_rx_word_unpack.sv
// Self-checking bench for udp_rx_word_unpack. Directed scenarios plus a
// randomized datagram stream checked against a byte-level reference model.
// A second instance with the port filter disabled shadows the main one.

module tb_udp_rx_word_unpack;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        udp_rx_hdr_valid = 1'b0;
  logic        udp_rx_hdr_ready;
  logic [15:0] udp_rx_dest_port = 16'h0000;
  logic        udp_rx_payload_valid = 1'b0;
  logic        udp_rx_payload_ready;
  logic        udp_rx_payload_last = 1'b0;
  logic [7:0]  udp_rx_payload_data = 8'h00;
  logic [15:0] o_data;
  logic        o_valid;
  logic        i_ready = 1'b0;
  logic        o_err_odd;
  logic        o_drop;

  // Filter-disabled shadow: sees a beat only when the main DUT accepts it.
  logic        nf_hdr_valid, nf_payload_valid;
  logic        nf_hdr_ready, nf_payload_ready;
  logic [15:0] nf_o_data;
  logic        nf_o_valid, nf_o_err_odd, nf_o_drop;
  logic        nf_ready = 1'b1;

  assign nf_hdr_valid     = udp_rx_hdr_valid && udp_rx_hdr_ready;
  assign nf_payload_valid = udp_rx_payload_valid && udp_rx_payload_ready;

  int n_checks = 0;
  int n_pass   = 0;
  int err_cnt  = 0;
  int drop_cnt = 0;
  logic [15:0] got_q[$];
  logic [15:0] nf_q[$];

  udp_rx_word_unpack #(.DEPTH(4), .PORT(16'd1234), .FILTER_EN(1'b1)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .udp_rx_hdr_valid(udp_rx_hdr_valid), .udp_rx_hdr_ready(udp_rx_hdr_ready),
    .udp_rx_dest_port(udp_rx_dest_port),
    .udp_rx_payload_valid(udp_rx_payload_valid), .udp_rx_payload_ready(udp_rx_payload_ready),
    .udp_rx_payload_last(udp_rx_payload_last), .udp_rx_payload_data(udp_rx_payload_data),
    .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_err_odd(o_err_odd), .o_drop(o_drop)
  );

  udp_rx_word_unpack #(.DEPTH(4), .PORT(16'd1234), .FILTER_EN(1'b0)) dut_nf (
    .i_clk(i_clk), .i_rst(i_rst),
    .udp_rx_hdr_valid(nf_hdr_valid), .udp_rx_hdr_ready(nf_hdr_ready),
    .udp_rx_dest_port(udp_rx_dest_port),
    .udp_rx_payload_valid(nf_payload_valid), .udp_rx_payload_ready(nf_payload_ready),
    .udp_rx_payload_last(udp_rx_payload_last), .udp_rx_payload_data(udp_rx_payload_data),
    .o_data(nf_o_data), .o_valid(nf_o_valid), .i_ready(nf_ready),
    .o_err_odd(nf_o_err_odd), .o_drop(nf_o_drop)
  );

  always #5 i_clk = ~i_clk;

  // Observe at the falling edge: a pop/pulse seen here belongs to the next rising edge.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_valid && i_ready) got_q.push_back(o_data);
      if (o_err_odd) err_cnt++;
      if (o_drop) drop_cnt++;
      if (nf_o_valid) nf_q.push_back(nf_o_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic send_hdr(input logic [15:0] port);
    int n;
    n = 0;
    udp_rx_hdr_valid = 1'b1;
    udp_rx_dest_port = port;
    @(negedge i_clk);
    while (!udp_rx_hdr_ready && n < 200) begin n++; @(negedge i_clk); end
    if (!udp_rx_hdr_ready) begin
      n_checks++;
      $display("FAIL hdr_timeout: hdr_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge i_clk); #1;
    udp_rx_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    udp_rx_payload_valid = 1'b1;
    udp_rx_payload_data  = d;
    udp_rx_payload_last  = l;
    @(negedge i_clk);
    while (!udp_rx_payload_ready && n < 200) begin n++; @(negedge i_clk); end
    if (!udp_rx_payload_ready) begin
      n_checks++;
      $display("FAIL payload_timeout: payload_ready stayed 0 for %0d cycles, required 1", n);
    end
    @(posedge i_clk); #1;
    udp_rx_payload_valid = 1'b0;
    udp_rx_payload_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset;
    i_rst = 1'b1;
    idle(2);
    i_rst = 1'b0;
    idle(1);
    check("reset_hdr_ready", 32'(udp_rx_hdr_ready), 32'd1);
    check("reset_payload_ready", 32'(udp_rx_payload_ready), 32'd0);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_data", 32'(o_data), 32'h0);
    check("reset_o_err_odd", 32'(o_err_odd), 32'd0);
    check("reset_o_drop", 32'(o_drop), 32'd0);
  endtask

  task automatic test_basic_word;
    got_q.delete();
    i_ready = 1'b1;
    send_hdr(16'd1234);
    send_byte(8'hAB, 1'b0);
    send_byte(8'hCD, 1'b1);
    check("basic_o_valid", 32'(o_valid), 32'd1);
    check("basic_o_data", 32'(o_data), 32'hABCD);
    check("basic_hdr_ready", 32'(udp_rx_hdr_ready), 32'd1);
    idle(3);
    check("basic_word_count", 32'(got_q.size()), 32'd1);
  endtask

  task automatic test_odd_length;
    int e0;
    got_q.delete();
    e0 = err_cnt;
    i_ready = 1'b1;
    send_hdr(16'd1234);
    send_byte(8'h12, 1'b0);
    send_byte(8'h34, 1'b0);
    send_byte(8'h56, 1'b1);
    idle(4);
    check("odd_err_pulse_cycles", 32'(err_cnt - e0), 32'd1);
    check("odd_word_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() > 0) check("odd_word", 32'(got_q[0]), 32'h1234);
    check("odd_o_valid_after", 32'(o_valid), 32'd0);
  endtask

  task automatic test_port_filter;
    logic [7:0] b [4];
    int d0;
    got_q.delete();
    nf_q.delete();
    d0 = drop_cnt;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
    send_hdr(16'd80);
    for (int i = 0; i < 4; i++) send_byte(b[i], (i == 3) ? 1'b1 : 1'b0);
    idle(4);
    check("filter_drop_pulse_cycles", 32'(drop_cnt - d0), 32'd1);
    check("filter_words_out", 32'(got_q.size()), 32'd0);
    check("filter_hdr_ready", 32'(udp_rx_hdr_ready), 32'd1);
    check("nofilter_words_out", 32'(nf_q.size()), 32'd2);
    if (nf_q.size() == 2) begin
      check("nofilter_word0", 32'(nf_q[0]), 32'({b[0], b[1]}));
      check("nofilter_word1", 32'(nf_q[1]), 32'({b[2], b[3]}));
    end
  endtask

  task automatic test_fifo_full;
    int n;
    logic [15:0] exp_w;
    got_q.delete();
    i_ready = 1'b0;
    send_hdr(16'd1234);
    for (int i = 1; i <= 9; i++) send_byte(8'(i), 1'b0);
    udp_rx_payload_valid = 1'b1;
    udp_rx_payload_data  = 8'h0A;
    udp_rx_payload_last  = 1'b1;
    repeat (3) @(negedge i_clk);
    check("full_payload_ready", 32'(udp_rx_payload_ready), 32'd0);
    check("full_o_valid", 32'(o_valid), 32'd1);
    check("full_head", 32'(o_data), 32'h0102);
    @(posedge i_clk); #1;
    i_ready = 1'b1;
    @(posedge i_clk); #1;
    i_ready = 1'b0;
    n = 0;
    @(negedge i_clk);
    while (!udp_rx_payload_ready && n < 50) begin n++; @(negedge i_clk); end
    check("full_resume_ready", 32'(udp_rx_payload_ready), 32'd1);
    @(posedge i_clk); #1;
    udp_rx_payload_valid = 1'b0;
    udp_rx_payload_last  = 1'b0;
    i_ready = 1'b1;
    idle(10);
    check("full_drain_count", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++) begin
      exp_w = {8'(2*i + 1), 8'(2*i + 2)};
      check("full_drain_word", 32'(got_q[i]), 32'(exp_w));
    end
  endtask

  task automatic test_reset_mid;
    int stray;
    got_q.delete();
    i_ready = 1'b0;
    send_hdr(16'd1234);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    check("mid_valid_before_rst", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    check("mid_o_valid_async", 32'(o_valid), 32'd0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    idle(1);
    check("mid_hdr_ready", 32'(udp_rx_hdr_ready), 32'd1);
    check("mid_payload_ready", 32'(udp_rx_payload_ready), 32'd0);
    stray = 0;
    udp_rx_payload_valid = 1'b1;
    udp_rx_payload_data  = 8'h44;
    udp_rx_payload_last  = 1'b1;
    repeat (3) begin
      @(negedge i_clk);
      if (udp_rx_payload_ready) stray++;
    end
    check("mid_stray_beats_accepted", 32'(stray), 32'd0);
    @(posedge i_clk); #1;
    udp_rx_payload_valid = 1'b0;
    udp_rx_payload_last  = 1'b0;
    send_hdr(16'd1234);
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b1);
    check("mid_next_valid", 32'(o_valid), 32'd1);
    check("mid_next_data", 32'(o_data), 32'hBEEF);
    i_ready = 1'b1;
    idle(3);
    check("mid_next_count", 32'(got_q.size()), 32'd1);
  endtask

  task automatic test_random_stream;
    logic [15:0] exp_q[$];
    logic [7:0]  bytes[$];
    logic [15:0] port;
    int len, gap, e0, d0, exp_err, exp_drop;
    bit done;
    got_q.delete();
    e0 = err_cnt; d0 = drop_cnt;
    exp_err = 0; exp_drop = 0; done = 0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          len  = $urandom_range(1, 9);
          port = ($urandom_range(0, 1) == 1) ? 16'd1234 : 16'($urandom);
          bytes.delete();
          for (int i = 0; i < len; i++) bytes.push_back(8'($urandom));
          if (port != 16'd1234) begin
            exp_drop++;
          end else begin
            for (int i = 0; i + 1 < len; i += 2) exp_q.push_back({bytes[i], bytes[i+1]});
            if (len % 2 == 1) exp_err++;
          end
          send_hdr(port);
          for (int i = 0; i < len; i++) begin
            gap = $urandom_range(0, 2);
            if (gap != 0) idle(gap);
            send_byte(bytes[i], (i == len - 1) ? 1'b1 : 1'b0);
          end
        end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge i_clk); #1;
          i_ready = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
        end
      end
    join
    i_ready = 1'b1;
    idle(20);
    check("rand_word_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check("rand_word", 32'(got_q[i]), 32'(exp_q[i]));
    check("rand_err_pulses", 32'(err_cnt - e0), 32'(exp_err));
    check("rand_drop_pulses", 32'(drop_cnt - d0), 32'(exp_drop));
  endtask

  initial begin
    test_reset;
    test_basic_word;
    test_odd_length;
    test_port_filter;
    test_fifo_full;
    test_reset_mid;
    test_random_stream;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
